multi_clock_gater: RTL and testbench

- Parametrised, multi-channel successor to the single glitch-free clock gate.
- Produces NUM_CHANNELS gated clocks from one root clock.
- Each channel has an idle-detect FSM with a programmable hysteresis count, a force-on, and a wake request/acknowledge handshake.
- Sits at the clock root of the PIFO blocks, so idle pipeline stages and banks stop toggling without software involvement.

---
 rtl/multi_clock_gater.sv | 148 ++++++++++++++
 tb/tb_multi_clock_gater.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_clock_gater.sv
// Multi-channel glitch-free clock gater: per-channel idle-detect FSM with hysteresis,
// force-on, wake request/acknowledge, and a latch-based gate on each output clock.
`timescale 1ns/1ps

module multi_clock_gater #(
    parameter int NUM_CHANNELS   = 4,
    parameter int IDLE_CNT_WIDTH = 4,
    parameter int WAKE_CYCLES    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i__scan_en,
    input  logic [NUM_CHANNELS-1:0]     i__busy,
    input  logic [NUM_CHANNELS-1:0]     i__force_on,
    input  logic [NUM_CHANNELS-1:0]     i__wake_req,
    input  logic [IDLE_CNT_WIDTH-1:0]   i__idle_threshold,
    output logic [NUM_CHANNELS-1:0]     o__wake_ack,
    output logic [NUM_CHANNELS-1:0]     o__clk_en,
    output logic                        o__all_off,
    output logic [NUM_CHANNELS-1:0]     o__gated_clk,
    output logic [2*NUM_CHANNELS-1:0]   o__dbg_state
);

    typedef enum logic [1:0] {
        ST_ON    = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OFF   = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    // Wake counter covers the full legal WAKE_CYCLES range of 1..15.
    localparam int                        WAKE_CNT_WIDTH = 4;
    localparam logic [WAKE_CNT_WIDTH-1:0] WAKE_LAST      = WAKE_CNT_WIDTH'(WAKE_CYCLES - 1);
    localparam logic [IDLE_CNT_WIDTH-1:0] IDLE_MAX       = '1;
    localparam logic [IDLE_CNT_WIDTH-1:0] IDLE_ONE       = IDLE_CNT_WIDTH'(1);

    logic [NUM_CHANNELS-1:0] off_vec;
    logic                    thr_zero;

    assign thr_zero = (i__idle_threshold == '0);

    // Wake handshake: a requester raises i__wake_req and holds it until o__wake_ack
    // is seen high; ack rises on the edge the channel is (or stays) in ON with the
    // request present, stays high while the request is held, and drops on the first
    // edge the request is seen low. The request also counts as activity.
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        state_e                    state_q, state_d;
        logic [IDLE_CNT_WIDTH-1:0] idle_q, idle_d;
        logic [WAKE_CNT_WIDTH-1:0] wake_q, wake_d;
        logic                      en_q, en_d;
        logic                      ack_q, ack_d;
        logic                      act;
        logic                      en_mux;
        logic                      en_lat;

        assign act = i__busy[g] | i__force_on[g] | i__wake_req[g];

        always_comb begin
            state_d = state_q;
            idle_d  = idle_q;
            wake_d  = wake_q;
            unique case (state_q)
                ST_ON: begin
                    idle_d = '0;
                    if (!act && !thr_zero) begin
                        state_d = ST_DRAIN;
                        idle_d  = IDLE_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (act || thr_zero) begin
                        state_d = ST_ON;
                        idle_d  = '0;
                    end else if (idle_q >= i__idle_threshold) begin
                        state_d = ST_OFF;
                    end else if (idle_q != IDLE_MAX) begin
                        idle_d = idle_q + IDLE_ONE;
                    end
                end
                ST_OFF: begin
                    if (act) begin
                        state_d = ST_WAKE;
                        wake_d  = '0;
                        idle_d  = '0;
                    end
                end
                ST_WAKE: begin
                    // The wake sequence always completes, even if activity vanishes.
                    if (wake_q == WAKE_LAST) begin
                        state_d = ST_ON;
                        wake_d  = '0;
                        idle_d  = '0;
                    end else begin
                        wake_d = wake_q + WAKE_CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = ST_ON;
                    idle_d  = '0;
                    wake_d  = '0;
                end
            endcase
            en_d  = (state_d != ST_OFF);
            ack_d = i__wake_req[g] & (ack_q | (state_d == ST_ON));
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ST_ON;
                idle_q  <= '0;
                wake_q  <= '0;
                en_q    <= 1'b1;
                ack_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                idle_q  <= idle_d;
                wake_q  <= wake_d;
                en_q    <= en_d;
                ack_q   <= ack_d;
            end
        end

        // Latch is transparent only while clk is low, so the AND below never
        // sees the enable change during the high phase.
        assign en_mux = en_q | i__scan_en;

        always_latch begin
            if (!clk) begin
                en_lat = en_mux;
            end
        end

        assign o__gated_clk[g]        = clk & en_lat;
        assign o__clk_en[g]           = en_q;
        assign o__wake_ack[g]         = ack_q;
        assign off_vec[g]             = (state_q == ST_OFF);
        assign o__dbg_state[2*g +: 2] = state_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o__all_off <= 1'b0;
        end else begin
            o__all_off <= &off_vec;
        end
    end

endmodule

// File: tb/tb_multi_clock_gater.sv
// Self-checking bench for multi_clock_gater: directed scenarios plus randomized
// traffic compared against a counter-based behavioural model of each channel.
`timescale 1ns/1ps

module tb_multi_clock_gater;
    localparam int N  = 4;
    localparam int IW = 4;
    localparam int WC = 2;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          scan_en  = 1'b0;
    logic [N-1:0]  busy     = '0;
    logic [N-1:0]  force_on = '0;
    logic [N-1:0]  wake_req = '0;
    logic [IW-1:0] thr      = IW'(3);

    logic [N-1:0]   o__wake_ack;
    logic [N-1:0]   o__clk_en;
    logic           o__all_off;
    logic [N-1:0]   o__gated_clk;
    logic [2*N-1:0] o__dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    multi_clock_gater #(
        .NUM_CHANNELS   (N),
        .IDLE_CNT_WIDTH (IW),
        .WAKE_CYCLES    (WC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .i__scan_en        (scan_en),
        .i__busy           (busy),
        .i__force_on       (force_on),
        .i__wake_req       (wake_req),
        .i__idle_threshold (thr),
        .o__wake_ack       (o__wake_ack),
        .o__clk_en         (o__clk_en),
        .o__all_off        (o__all_off),
        .o__gated_clk      (o__gated_clk),
        .o__dbg_state      (o__dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each channel: off flag, remaining wake cycles, and the length of the
    // current idle run (0 means fully on).
    bit m_off [N];
    int m_wake[N];
    int m_idle[N];
    bit m_ack [N];
    bit m_lat [N];
    bit m_all_off;
    bit m_all_now;
    bit m_act;
    bit m_on;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                m_off[i]  = 1'b0;
                m_wake[i] = 0;
                m_idle[i] = 0;
                m_ack[i]  = 1'b0;
                if (clk) m_lat[i] = 1'b1;
            end
            m_all_off = 1'b0;
        end else begin
            m_all_now = 1'b1;
            for (int i = 0; i < N; i++) begin
                m_all_now = m_all_now & m_off[i];
                m_lat[i]  = !m_off[i] || scan_en;
            end
            m_all_off = m_all_now;
            for (int i = 0; i < N; i++) begin
                m_act = busy[i] | force_on[i] | wake_req[i];
                if (m_off[i]) begin
                    if (m_act) begin
                        m_off[i]  = 1'b0;
                        m_wake[i] = WC;
                        m_idle[i] = 0;
                    end
                end else if (m_wake[i] > 0) begin
                    m_wake[i]--;
                end else if (m_act || thr == 0) begin
                    m_idle[i] = 0;
                end else if (m_idle[i] == 0) begin
                    m_idle[i] = 1;
                end else if (m_idle[i] >= int'(thr)) begin
                    m_off[i] = 1'b1;
                end else begin
                    m_idle[i]++;
                end
                m_on     = !m_off[i] && m_wake[i] == 0 && m_idle[i] == 0;
                m_ack[i] = wake_req[i] && (m_ack[i] || m_on);
            end
        end
    end

    function automatic logic [3*N:0] exp_vec();
        logic [N-1:0] a, e, g;
        for (int i = 0; i < N; i++) begin
            a[i] = m_ack[i];
            e[i] = !m_off[i];
            g[i] = m_lat[i];
        end
        return {a, e, m_all_off, g};
    endfunction

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        thr   = IW'(3);
        repeat (3) tick();
        n_checks++;
        if (o__clk_en !== 4'hF) $display("FAIL reset_clk_en got=%h exp=f", o__clk_en);
        else n_pass++;
        n_checks++;
        if (o__wake_ack !== 4'h0) $display("FAIL reset_ack got=%h exp=0", o__wake_ack);
        else n_pass++;
        n_checks++;
        if (o__all_off !== 1'b0) $display("FAIL reset_all_off got=%b exp=0", o__all_off);
        else n_pass++;
        n_checks++;
        if (o__gated_clk !== 4'hF) $display("FAIL reset_gated_high got=%h exp=f", o__gated_clk);
        else n_pass++;
        half();
        n_checks++;
        if (o__gated_clk !== 4'h0) $display("FAIL reset_gated_low got=%h exp=0", o__gated_clk);
        else n_pass++;
    endtask

    task automatic test_idle_gating();
        logic [N-1:0] exp_en, exp_g;
        logic         exp_all;
        reset = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp_en  = (e >= 4) ? 4'h0 : 4'hF;
            exp_all = (e >= 5);
            exp_g   = (e <= 4) ? 4'hF : 4'h0;
            n_checks++;
            if ({o__clk_en, o__all_off, o__gated_clk} !== {exp_en, exp_all, exp_g})
                $display("FAIL idle_timing e=%0d got=%h exp=%h", e,
                         {o__clk_en, o__all_off, o__gated_clk}, {exp_en, exp_all, exp_g});
            else n_pass++;
            n_checks++;
            if ({o__wake_ack, o__clk_en, o__all_off, o__gated_clk} !== exp_vec())
                $display("FAIL idle_model e=%0d got=%h exp=%h", e,
                         {o__wake_ack, o__clk_en, o__all_off, o__gated_clk}, exp_vec());
            else n_pass++;
            half();
            n_checks++;
            if (o__gated_clk !== 4'h0) $display("FAIL idle_runt e=%0d got=%h exp=0", e, o__gated_clk);
            else n_pass++;
        end
    endtask

    task automatic test_wake();
        wake_req[0] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            n_checks++;
            if ({o__clk_en[0], o__gated_clk[0], o__wake_ack[0], o__all_off} !==
                {1'b1, 1'(e >= 2), 1'(e >= 3), 1'(e == 1)})
                $display("FAIL wake_timing e=%0d got=%b exp=%b", e,
                         {o__clk_en[0], o__gated_clk[0], o__wake_ack[0], o__all_off},
                         {1'b1, 1'(e >= 2), 1'(e >= 3), 1'(e == 1)});
            else n_pass++;
            n_checks++;
            if ({o__wake_ack, o__clk_en, o__all_off, o__gated_clk} !== exp_vec())
                $display("FAIL wake_model e=%0d got=%h exp=%h", e,
                         {o__wake_ack, o__clk_en, o__all_off, o__gated_clk}, exp_vec());
            else n_pass++;
            half();
        end
        wake_req[0] = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            n_checks++;
            if ({o__wake_ack[0], o__clk_en[0]} !== {1'b0, 1'(e <= 3)})
                $display("FAIL wake_release e=%0d got=%b exp=%b", e,
                         {o__wake_ack[0], o__clk_en[0]}, {1'b0, 1'(e <= 3)});
            else n_pass++;
            n_checks++;
            if ({o__wake_ack, o__clk_en, o__all_off, o__gated_clk} !== exp_vec())
                $display("FAIL release_model e=%0d got=%h exp=%h", e,
                         {o__wake_ack, o__clk_en, o__all_off, o__gated_clk}, exp_vec());
            else n_pass++;
            half();
        end
    endtask

    task automatic test_threshold_zero();
        busy = 4'hF;
        repeat (3) begin
            tick();
            half();
        end
        busy = 4'h0;
        thr  = IW'(0);
        for (int e = 1; e <= 50; e++) begin
            tick();
            n_checks++;
            if ({o__clk_en, o__all_off, o__gated_clk} !== {4'hF, 1'b0, 4'hF})
                $display("FAIL thr0_enabled e=%0d got=%h exp=%h", e,
                         {o__clk_en, o__all_off, o__gated_clk}, {4'hF, 1'b0, 4'hF});
            else n_pass++;
            half();
            n_checks++;
            if (o__gated_clk !== 4'h0) $display("FAIL thr0_low e=%0d got=%h exp=0", e, o__gated_clk);
            else n_pass++;
        end
    endtask

    task automatic test_threshold_change();
        logic [N-1:0] exp_en;
        thr = IW'(5);
        for (int e = 1; e <= 3; e++) begin
            if (e == 3) thr = IW'(1);
            tick();
            exp_en = (e == 3) ? 4'h0 : 4'hF;
            n_checks++;
            if (o__clk_en !== exp_en)
                $display("FAIL thr_lower e=%0d got=%h exp=%h", e, o__clk_en, exp_en);
            else n_pass++;
            half();
        end
        busy = 4'hF;
        repeat (3) begin
            tick();
            half();
        end
        thr = IW'(3);
        for (int e = 1; e <= 7; e++) begin
            busy = (e == 3) ? 4'b0100 : 4'b0000;
            tick();
            exp_en = (e <= 3) ? 4'hF : (e <= 6) ? 4'b0100 : 4'h0;
            n_checks++;
            if (o__clk_en !== exp_en)
                $display("FAIL busy_restart e=%0d got=%h exp=%h", e, o__clk_en, exp_en);
            else n_pass++;
            n_checks++;
            if ({o__wake_ack, o__clk_en, o__all_off, o__gated_clk} !== exp_vec())
                $display("FAIL restart_model e=%0d got=%h exp=%h", e,
                         {o__wake_ack, o__clk_en, o__all_off, o__gated_clk}, exp_vec());
            else n_pass++;
            half();
        end
        busy = 4'h0;
    endtask

    task automatic test_scan();
        scan_en = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            n_checks++;
            if ({o__gated_clk, o__clk_en, o__all_off} !== {4'hF, 4'h0, 1'b1})
                $display("FAIL scan_bypass e=%0d got=%h exp=%h", e,
                         {o__gated_clk, o__clk_en, o__all_off}, {4'hF, 4'h0, 1'b1});
            else n_pass++;
            half();
            n_checks++;
            if (o__gated_clk !== 4'h0) $display("FAIL scan_low e=%0d got=%h exp=0", e, o__gated_clk);
            else n_pass++;
        end
        scan_en = 1'b0;
        tick();
        n_checks++;
        if ({o__wake_ack, o__clk_en, o__all_off, o__gated_clk} !== exp_vec())
            $display("FAIL scan_exit got=%h exp=%h",
                     {o__wake_ack, o__clk_en, o__all_off, o__gated_clk}, exp_vec());
        else n_pass++;
        n_checks++;
        if (o__gated_clk !== 4'h0) $display("FAIL scan_exit_gate got=%h exp=0", o__gated_clk);
        else n_pass++;
        half();
    endtask

    task automatic test_async_reset();
        thr      = IW'(3);
        wake_req = 4'b0001;
        tick();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({o__clk_en, o__wake_ack, o__all_off} !== {4'hF, 4'h0, 1'b0})
            $display("FAIL async_reset got=%h exp=%h",
                     {o__clk_en, o__wake_ack, o__all_off}, {4'hF, 4'h0, 1'b0});
        else n_pass++;
        wake_req = 4'b0000;
        tick();
        n_checks++;
        if (o__gated_clk !== 4'hF) $display("FAIL reset_resume got=%h exp=f", o__gated_clk);
        else n_pass++;
        half();
        reset = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            n_checks++;
            if ({o__clk_en, o__gated_clk} !== {((e <= 3) ? 4'hF : 4'h0), ((e <= 4) ? 4'hF : 4'h0)})
                $display("FAIL post_reset_drain e=%0d got=%h exp=%h", e, {o__clk_en, o__gated_clk},
                         {((e <= 3) ? 4'hF : 4'h0), ((e <= 4) ? 4'hF : 4'h0)});
            else n_pass++;
            half();
            n_checks++;
            if (o__gated_clk !== 4'h0) $display("FAIL post_reset_runt e=%0d got=%h exp=0", e, o__gated_clk);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                busy[i]     = ($urandom_range(0, 9) == 0);
                force_on[i] = ($urandom_range(0, 24) == 0);
                if (!wake_req[i] && $urandom_range(0, 19) == 0) wake_req[i] = 1'b1;
                else if (wake_req[i] && m_ack[i] && $urandom_range(0, 2) == 0) wake_req[i] = 1'b0;
            end
            scan_en = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) thr = IW'($urandom_range(0, 6));
            tick();
            n_checks++;
            if ({o__wake_ack, o__clk_en, o__all_off, o__gated_clk} !== exp_vec())
                $display("FAIL random c=%0d got=%h exp=%h", c,
                         {o__wake_ack, o__clk_en, o__all_off, o__gated_clk}, exp_vec());
            else n_pass++;
            half();
            n_checks++;
            if (o__gated_clk !== 4'h0) $display("FAIL random_low c=%0d got=%h exp=0", c, o__gated_clk);
            else n_pass++;
        end
        busy     = '0;
        force_on = '0;
        scan_en  = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_idle_gating();
        test_wake();
        test_threshold_zero();
        test_threshold_change();
        test_scan();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
